// File: rtl/serial_adder_2x1_mux_pkg.sv
// Shared definitions for the bit-serial mux-built adder/subtractor family.
// FSM encoding is common to both arithmetic variants.
package serial_adder_2x1_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_2x1_cell.sv
// Single 2:1 multiplexer cell; the only datapath primitive
// used to build the serial full-adder bit.
module mux_2x1_cell (
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/serial_adder_2x1_mux.sv
// LSB-first bit-serial adder, one bit per clock, valid/ready on
// both sides, full-adder bit built purely from 2:1 mux cells.
module serial_adder_2x1_mux
  import serial_adder_2x1_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic x;
  logic s;
  logic co;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  // x = a^b, s = x^c, co = x ? c : a (majority)
  mux_2x1_cell u_x (
    .in0 (b_sr[0]),
    .in1 (~b_sr[0]),
    .sel (a_sr[0]),
    .out (x)
  );

  mux_2x1_cell u_s (
    .in0 (x),
    .in1 (~x),
    .sel (carry),
    .out (s)
  );

  mux_2x1_cell u_co (
    .in0 (a_sr[0]),
    .in1 (carry),
    .sel (x),
    .out (co)
  );

  assign sum_nxt = {s, sum_sr[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          carry  <= co;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum       <= sum_nxt;
            cout      <= co;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_2x1_mux.sv
// Bench for serial_adder_2x1_mux: vector table, multi-cycle corner
// sequences and a randomized back-to-back run against an arithmetic model.
module tb_serial_adder_2x1_mux;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp;
  int n_fail;

  serial_adder_2x1_mux #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // accept one operand set, wait for result; lat = edges from accept
  task automatic start_op(input logic [W-1:0] va,
                          input logic [W-1:0] vb,
                          input logic vc,
                          output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t vecs[8];
  logic [W:0] expq[$];
  int lat;
  int acc_cnt;
  int cyc;
  int last_acc;
  int res_cnt;
  int t;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[7] = '{8'h55, 8'h2A, 1'b1, 8'h80, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), W);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      consume();
      check($sformatf("vec%0d_idle", i), 32'(out_valid), 0);
    end

    // hold result in DONE while the consumer stalls
    start_op(8'h1E, 8'h1E, 1'b0, lat);
    check("hold_lat", 32'(lat), W);
    for (int i = 0; i < 5; i++) begin
      a = 8'hC3;
      b = 8'h99;
      cin = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("hold%0d_sum", i), 32'(sum), 32'h3C);
      check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    consume();
    check("hold_after_valid", 32'(out_valid), 0);
    check("hold_after_sum", 32'(sum), 32'h3C);
    check("hold_after_in_ready", 32'(in_ready), 1);
    repeat (2) @(negedge clk);
    check("hold_no_capture", 32'(in_ready), 1);

    // asynchronous reset in the middle of an operation
    a = 8'h77;
    b = 8'h11;
    cin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(sum), 0);
    check("mid_rst_cout", 32'(cout), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    start_op(8'h12, 8'h34, 1'b0, lat);
    check("post_rst_lat", 32'(lat), W);
    check("post_rst_sum", 32'(sum), 32'h46);
    check("post_rst_cout", 32'(cout), 0);
    consume();

    // back-to-back random traffic, both handshakes tied high
    acc_cnt = 0;
    res_cnt = 0;
    cyc = 0;
    last_acc = -1;
    out_ready = 1'b1;
    t = 0;
    while ((acc_cnt < 100 || expq.size() != 0) && t < 5000) begin
      @(negedge clk);
      cyc++;
      t++;
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("b2b_unexpected_result", 1, 0);
        end else begin
          logic [W:0] e;
          e = expq.pop_front();
          check($sformatf("b2b%0d_result", res_cnt),
                32'({cout, sum}), 32'(e));
          res_cnt++;
        end
      end
      if (acc_cnt < 100) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        in_valid = 1'b1;
        if (in_ready) begin
          expq.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(cin));
          if (last_acc >= 0)
            check($sformatf("b2b%0d_spacing", acc_cnt),
                  32'(cyc - last_acc), W + 2);
          last_acc = cyc;
          acc_cnt++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    if (t >= 5000) check("b2b_timeout", 0, 1);
    check("b2b_results", 32'(res_cnt), 100);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
